mult_operand_feeder: RTL

MULT_OPERAND_FEEDER -- requirements
Module: mult_operand_feeder

---
 rtl/mult_operand_feeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder: FIFO-buffered operand feeder driving a start/finish add-shift multiplier
// Ports: in_valid/in_ready/in_a/in_b push operand pairs; mul_start/mul_a/mul_b launch one multiply,
//        mul_finish/mul_out return it; res_valid/res_ready/res_data hold the product until consumed;
//        count is FIFO occupancy; err is a sticky multiplier-timeout flag; reset is async active-low.
module mult_operand_feeder #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic                   mul_start,
  output logic [N-1:0]           mul_a,
  output logic [N-1:0]           mul_b,
  input  logic                   mul_finish,
  input  logic [2*N:0]           mul_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*N:0]           res_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] mem_q [DEPTH];
  logic [2*N-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [2*N:0] res_q, res_d;
  logic res_valid_q, res_valid_d, err_q, err_d;
  logic push, pop, nonempty;
  assign in_ready  = count_q < FULL;
  assign mul_start = state_q == LAUNCH;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign count     = count_q;
  assign err       = err_q;
  always_comb begin
    nonempty    = count_q != '0;
    push        = in_valid && in_ready;
    pop         = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    a_d         = a_q;
    b_d         = b_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    case (state_q)
      IDLE: begin
        pop     = nonempty;
        state_d = nonempty ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a finish on the last allowed cycle still wins over the timeout
        if (mul_finish) begin
          res_d       = mul_out;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (wait_q == W_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          pop         = nonempty;
          state_d     = nonempty ? LAUNCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      {a_d, b_d} = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = {in_a, in_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end
endmodule
